// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with registered register-file write-back.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic [DATA_WIDTH-1:0] rs2_val,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  busy,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  neg_q, neg_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d, rem_q, rem_d;
    logic [2*W-1:0]        acc_q, acc_d;
    logic                  wb_we_q, wb_we_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [W-1:0]          wb_data_q, wb_data_d;

    logic          sa, sb, div0, ovf, special;
    logic [W-1:0]  mag_a, mag_b, quo, rmd, result;
    logic [W:0]    mul_sum, div_sh, div_diff;
    logic [2*W-1:0] prod;

    always_comb begin
        sa       = rs1_val[W-1] & (funct3 == 3'd1 | funct3 == 3'd2 | funct3 == 3'd4 | funct3 == 3'd6);
        sb       = rs2_val[W-1] & (funct3 == 3'd1 | funct3 == 3'd4 | funct3 == 3'd6);
        mag_a    = sa ? -rs1_val : rs1_val;
        mag_b    = sb ? -rs2_val : rs2_val;
        div0     = funct3[2] & (rs2_val == '0);
        ovf      = (funct3 == 3'd4 | funct3 == 3'd6) & (rs1_val == MIN_NEG) & (rs2_val == ONES);
        special  = div0 | ovf;
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_sh   = {rem_q, acc_q[W-1]};
        div_diff = div_sh - {1'b0, b_q};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rmd      = neg_q ? -rem_q : rem_q;
        result   = op_q[2] ? (op_q[1] ? rmd : quo) : (op_q == 3'd0 ? prod[W-1:0] : prod[2*W-1:W]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: if (start) begin
                op_d    = funct3;
                rd_d    = rd_addr;
                // special cases preload the final quotient/remainder so DONE needs no extra path
                neg_d   = special ? 1'b0 : (funct3 == 3'd6 ? sa : sa ^ sb);
                a_d     = mag_a;
                b_d     = mag_b;
                cnt_d   = '0;
                rem_d   = div0 ? rs1_val : '0;
                acc_d   = special ? {{W{1'b0}}, div0 ? ONES : MIN_NEG}
                                  : {{W{1'b0}}, funct3[2] ? mag_a : mag_b};
                state_d = special ? DONE : CALC;
            end
            CALC: begin
                acc_d   = op_q[2] ? {{W{1'b0}}, acc_q[W-2:0], ~div_diff[W]} : {mul_sum, acc_q[W-1:1]};
                rem_d   = op_q[2] ? (div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0]) : rem_q;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(W-1)) ? DONE : CALC;
            end
            DONE: begin
                wb_we_d   = rd_q != '0;
                wb_addr_d = rd_q;
                wb_data_d = result;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy    = state_q != IDLE;
    assign wb_we   = wb_we_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M vectors with hand-computed results, latency and reset checks.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    int checks = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
        .busy(busy), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat, input bit spam);
        int cyc, pulses, busy_cnt;
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_addr = rd;
        @(posedge clk); #1;
        if (spam) begin
            funct3 = 3'd5; rs1_val = 32'h0000_0063; rs2_val = 32'h0000_0009; rd_addr = 5'd9;
        end else start = 1'b0;
        cyc = 0; pulses = 0; busy_cnt = busy ? 1 : 0;
        while (busy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_cnt++;
            if (wb_we) pulses++;
        end
        start = 1'b0;
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " busy_cycles"}, busy_cnt, lat);
        chk({tag, " data"}, wb_data, exp);
        chk({tag, " addr"}, {27'b0, wb_addr}, {27'b0, rd});
        chk({tag, " we"}, {31'b0, wb_we}, {31'b0, rd != 5'd0});
        repeat (3) begin
            @(posedge clk); #1;
            if (wb_we) pulses++;
        end
        chk({tag, " pulses"}, pulses, (rd != 5'd0) ? 1 : 0);
        chk({tag, " idle_after"}, {31'b0, busy}, 32'd0);
        chk({tag, " hold"}, wb_data, exp);
    endtask

    initial begin
        int pulses;
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset we", {31'b0, wb_we}, 32'd0);
        chk("reset addr", {27'b0, wb_addr}, 32'd0);
        chk("reset data", wb_data, 32'd0);
        @(negedge clk); reset = 1'b0;

        do_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1'b0);
        do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33, 1'b0);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, 1'b0);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF, 33, 1'b0);
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4, 32'hFFFF_FFFD, 33, 1'b0);
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF, 33, 1'b0);
        do_op("div_negb", 3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 33, 1'b0);
        do_op("rem_negb", 3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd15, 32'h0000_0001, 33, 1'b0);
        do_op("divu", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b0);
        do_op("remu", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33, 1'b0);
        do_op("divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 33, 1'b0);
        do_op("div0", 3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 1'b0);
        do_op("rem0", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1, 1'b0);
        do_op("divu0", 3'd5, 32'd5, 32'd0, 5'd17, 32'hFFFF_FFFF, 1, 1'b0);
        do_op("remu0", 3'd7, 32'd5, 32'd0, 5'd18, 32'd5, 1, 1'b0);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 1'b0);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1, 1'b0);
        do_op("mul_spam", 3'd0, 32'h0001_2345, 32'h0000_0100, 5'd13, 32'h0123_4500, 33, 1'b1);
        do_op("rd0", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 33, 1'b0);

        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async busy", {31'b0, busy}, 32'd0);
        chk("async we", {31'b0, wb_we}, 32'd0);
        chk("async data", wb_data, 32'd0);
        chk("async addr", {27'b0, wb_addr}, 32'd0);
        @(negedge clk); reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (wb_we || busy) pulses++;
        end
        chk("post_reset quiet", pulses, 0);
        do_op("after_reset", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
